// File: rtl/dspl_cap_nexysa7.sv
// Capture side of the 8-digit multiplexed 7-segment display bus.
// Samples the active-low anode and cathode buses, waits for a scan slot to
// hold still, decodes the segment glyph back to {en, hex, dp} per digit and
// ages each digit so that a digit which stops being refreshed drops its en bit.
// Optional build macro: DSPL_CAP_SYNC_EN adds a 2-flop synchronizer on the
// 16 input bits (for buses coming from pins or another clock domain).
module dspl_cap_nexysa7 #(
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] an,
    input  logic [7:0] dec_cat,
    output logic [5:0] d1,
    output logic [5:0] d2,
    output logic [5:0] d3,
    output logic [5:0] d4,
    output logic [5:0] d5,
    output logic [5:0] d6,
    output logic [5:0] d7,
    output logic [5:0] d8,
    output logic       frame_tick,
    output logic       an_err,
    output logic       seg_err
);

    localparam int            CW      = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
    // Acceptance happens on the edge where the counter moves to STABLE_CYCLES-1.
    localparam logic [CW-1:0] CNT_ACC = CW'(STABLE_CYCLES - 2);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    // en clears on the edge where the age counter becomes TIMEOUT_CYCLES.
    localparam logic [31:0]   AGE_LIM = 32'(TIMEOUT_CYCLES - 1);

    // Glyph to {valid, hex}. A..F all share one glyph on the driver side, so
    // that glyph is reported as F.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        case (seg)
            7'b0000001: return {1'b1, 4'h0};
            7'b1001111: return {1'b1, 4'h1};
            7'b0010010: return {1'b1, 4'h2};
            7'b0000110: return {1'b1, 4'h3};
            7'b1001100: return {1'b1, 4'h4};
            7'b0100100: return {1'b1, 4'h5};
            7'b0100000: return {1'b1, 4'h6};
            7'b0001111: return {1'b1, 4'h7};
            7'b0000000: return {1'b1, 4'h8};
            7'b0000100: return {1'b1, 4'h9};
            7'b0111000: return {1'b1, 4'hF};
            default:    return 5'b0_0000;
        endcase
    endfunction

    // Position of the asserted anode; only meaningful when exactly one is low.
    function automatic logic [2:0] low_index(input logic [7:0] an_low);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (an_low[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    logic [15:0] smp;

`ifdef DSPL_CAP_SYNC_EN
    logic [15:0] sync1_q;
    logic [15:0] sync2_q;

    // Two-flop synchronizer; idles at the all-off bus value.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= {an, dec_cat};
            sync2_q <= sync1_q;
        end
    end

    assign smp = sync2_q;
`else
    assign smp = {an, dec_cat};
`endif

    logic [15:0]   samp_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          accept;

    // Stability counter: restart on any change, saturate once the slot is settled.
    always_comb begin
        cnt_d  = '0;
        accept = 1'b0;
        if (smp == samp_q) begin
            cnt_d  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
            accept = (cnt_q == CNT_ACC);
        end
    end

    // Previous-sample register and stability counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            samp_q <= '1;
            cnt_q  <= '0;
        end else begin
            samp_q <= smp;
            cnt_q  <= cnt_d;
        end
    end

    // On an accepting edge smp equals samp_q, so decode from the register.
    logic [7:0] an_low;
    logic       one_low;
    logic       multi_low;
    logic [2:0] slot;
    logic [4:0] dec;

    assign an_low    = ~samp_q[15:8];
    assign one_low   = $onehot(an_low);
    assign multi_low = (an_low != 8'h00) && !one_low;
    assign slot      = low_index(an_low);
    assign dec       = seg_decode(samp_q[7:1]);

    logic [5:0]  d_q   [8];
    logic [5:0]  d_d   [8];
    logic [31:0] age_q [8];
    logic [31:0] age_d [8];
    logic [2:0]  last_q, last_d;
    logic        seen_q, seen_d;
    logic        tick_q, tick_d;
    logic        anerr_q, anerr_d;
    logic        segerr_q, segerr_d;

    // Digit capture, ageing and status pulses; a capture overrides a same-cycle timeout.
    always_comb begin
        d_d      = d_q;
        last_d   = last_q;
        seen_d   = seen_q;
        tick_d   = 1'b0;
        anerr_d  = 1'b0;
        segerr_d = 1'b0;
        for (int k = 0; k < 8; k++) begin
            age_d[k] = (age_q[k] == 32'hFFFF_FFFF) ? age_q[k] : age_q[k] + 32'd1;
            if (age_q[k] >= AGE_LIM) d_d[k][5] = 1'b0;
        end
        if (accept) begin
            if (multi_low) begin
                anerr_d = 1'b1;
            end else if (one_low) begin
                if (dec[4]) begin
                    d_d[slot]   = {1'b1, dec[3:0], ~samp_q[0]};
                    age_d[slot] = '0;
                    tick_d      = seen_q && (slot <= last_q);
                    last_d      = slot;
                    seen_d      = 1'b1;
                end else begin
                    segerr_d = 1'b1;
                end
            end
        end
    end

    // Captured digits, age counters, wrap tracking and pulse registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 8; k++) begin
                d_q[k]   <= '0;
                age_q[k] <= '0;
            end
            last_q   <= '0;
            seen_q   <= 1'b0;
            tick_q   <= 1'b0;
            anerr_q  <= 1'b0;
            segerr_q <= 1'b0;
        end else begin
            for (int k = 0; k < 8; k++) begin
                d_q[k]   <= d_d[k];
                age_q[k] <= age_d[k];
            end
            last_q   <= last_d;
            seen_q   <= seen_d;
            tick_q   <= tick_d;
            anerr_q  <= anerr_d;
            segerr_q <= segerr_d;
        end
    end

    assign d1         = d_q[0];
    assign d2         = d_q[1];
    assign d3         = d_q[2];
    assign d4         = d_q[3];
    assign d5         = d_q[4];
    assign d6         = d_q[5];
    assign d7         = d_q[6];
    assign d8         = d_q[7];
    assign frame_tick = tick_q;
    assign an_err     = anerr_q;
    assign seg_err    = segerr_q;

endmodule

// File: tb/tb_dspl_cap_nexysa7.sv
// Bench for dspl_cap_nexysa7: directed scan-slot stimulus, a behavioural
// model built from the slot-acceptance rules (sample history, capture times),
// a per-cycle compare process and hand-computed literal checks.
module tb_dspl_cap_nexysa7;

    localparam int STABLE = 16;
    localparam int TMO    = 200;
`ifdef DSPL_CAP_SYNC_EN
    localparam int SYNC_D = 2;
`else
    localparam int SYNC_D = 0;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] an;
    logic [7:0] dec_cat;
    logic [5:0] d1, d2, d3, d4, d5, d6, d7, d8;
    logic       frame_tick, an_err, seg_err;

    always #5 clock = ~clock;

    dspl_cap_nexysa7 #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TMO)) dut (
        .clock(clock), .reset(reset), .an(an), .dec_cat(dec_cat),
        .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6), .d7(d7), .d8(d8),
        .frame_tick(frame_tick), .an_err(an_err), .seg_err(seg_err)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int ft_cnt  = 0;
    int ae_cnt  = 0;
    int se_cnt  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] glyph(input int v);
        case (v)
            0: return 7'b0000001;  1: return 7'b1001111;  2: return 7'b0010010;
            3: return 7'b0000110;  4: return 7'b1001100;  5: return 7'b0100100;
            6: return 7'b0100000;  7: return 7'b0001111;  8: return 7'b0000000;
            9: return 7'b0000100;  default: return 7'b0111000;
        endcase
    endfunction

    function automatic int seg2hex(input logic [6:0] s);
        for (int v = 0; v < 11; v++) begin
            if (glyph(v) == s) return (v == 10) ? 15 : v;
        end
        return -1;
    endfunction

    // ---------------- behavioural model ----------------
    logic [5:0]  m_d [8];
    logic        m_ft, m_ae, m_se;
    logic [15:0] hist[$];
    logic [15:0] m_s1, m_s2, m_s;
    int          cyc;
    int          last_cap [8];
    int          m_last;
    bit          m_seen;
    bit          m_acc;
    int          m_k, m_h;
    logic [7:0]  m_anl;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 8; k++) begin
                m_d[k] = '0;
                last_cap[k] = 0;
            end
            m_ft = 0; m_ae = 0; m_se = 0;
            hist = {};
            hist.push_back(16'hFFFF);
            m_s1 = 16'hFFFF; m_s2 = 16'hFFFF;
            cyc = 0; m_last = 0; m_seen = 0;
        end else begin
`ifdef DSPL_CAP_SYNC_EN
            m_s  = m_s2;
            m_s2 = m_s1;
            m_s1 = {an, dec_cat};
`else
            m_s = {an, dec_cat};
`endif
            cyc++;
            m_ft = 0; m_ae = 0; m_se = 0;
            hist.push_back(m_s);
            if (hist.size() > STABLE + 1) void'(hist.pop_front());
            // accepted when the newest STABLE samples agree and the one before differs
            m_acc = 0;
            if (hist.size() >= STABLE) begin
                m_acc = 1;
                for (int i = hist.size() - STABLE; i < hist.size(); i++)
                    if (hist[i] != m_s) m_acc = 0;
                if (hist.size() > STABLE && hist[0] == m_s) m_acc = 0;
            end
            for (int k = 0; k < 8; k++)
                if (cyc - last_cap[k] >= TMO) m_d[k][5] = 1'b0;
            if (m_acc) begin
                m_anl = ~m_s[15:8];
                if ($countones(m_anl) > 1) begin
                    m_ae = 1;
                end else if ($countones(m_anl) == 1) begin
                    m_k = 0;
                    for (int i = 0; i < 8; i++) if (m_anl[i]) m_k = i;
                    m_h = seg2hex(m_s[7:1]);
                    if (m_h < 0) begin
                        m_se = 1;
                    end else begin
                        m_d[m_k] = {1'b1, 4'(m_h), ~m_s[0]};
                        last_cap[m_k] = cyc;
                        if (m_seen && m_k <= m_last) m_ft = 1;
                        m_last = m_k;
                        m_seen = 1;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [5:0] dd [8];
    assign dd[0] = d1; assign dd[1] = d2; assign dd[2] = d3; assign dd[3] = d4;
    assign dd[4] = d5; assign dd[5] = d6; assign dd[6] = d7; assign dd[7] = d8;

    always @(negedge clock) begin
        for (int k = 0; k < 8; k++) chk($sformatf("cyc_d%0d", k + 1), 32'(dd[k]), 32'(m_d[k]));
        chk("cyc_frame_tick", 32'(frame_tick), 32'(m_ft));
        chk("cyc_an_err", 32'(an_err), 32'(m_ae));
        chk("cyc_seg_err", 32'(seg_err), 32'(m_se));
        if (frame_tick === 1'b1) ft_cnt++;
        if (an_err === 1'b1) ae_cnt++;
        if (seg_err === 1'b1) se_cnt++;
    end

    // ---------------- stimulus ----------------
    task automatic hold(input logic [7:0] a, input logic [7:0] c, input int n);
        an = a;
        dec_cat = c;
        repeat (n) @(posedge clock);
        #1;
    endtask

    int ft0, ae0, se0;

    initial begin
        reset = 1'b1;
        an = 8'hFF;
        dec_cat = 8'hFF;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // idle blank bus
        hold(8'hFF, 8'hFF, 100);
        chk("t1_d1", 32'(d1), 32'h0);
        chk("t1_d8", 32'(d8), 32'h0);
        chk("t1_pulses", 32'(ft_cnt + ae_cnt + se_cnt), 32'd0);

        // single slot, exact latency
        hold(8'hFE, 8'b0010010_1, STABLE - 1 + SYNC_D);
        chk("t2_before", 32'(d1), 32'h0);
        hold(8'hFE, 8'b0010010_1, 1);
        chk("t2_latency", 32'(d1), 32'(6'b1_0010_0));
        hold(8'hFE, 8'b0010010_1, 3);
        chk("t2_d2", 32'(d2), 32'h0);
        chk("t2_no_tick", 32'(ft_cnt), 32'd0);

        // full scan 0..7 then slot 0 again
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        ft0 = ft_cnt;
        for (int k = 0; k < 8; k++)
            hold(~(8'h01 << k), {glyph(k + 1), (k == 3) ? 1'b0 : 1'b1}, 20);
        chk("t3_no_tick_yet", 32'(ft_cnt - ft0), 32'd0);
        hold(8'hFE, {glyph(1), 1'b1}, 20);
        chk("t3_d4", 32'(d4), 32'(6'b1_0100_1));
        chk("t3_d8", 32'(d8), 32'(6'b1_1000_0));
        chk("t3_tick_once", 32'(ft_cnt - ft0), 32'd1);

        // anode and segment errors
        ae0 = ae_cnt;
        se0 = se_cnt;
        hold(8'hFC, {glyph(5), 1'b1}, 20);
        chk("t4_an_err_once", 32'(ae_cnt - ae0), 32'd1);
        chk("t4_d1_kept", 32'(d1), 32'(6'b1_0001_0));
        hold(8'hFB, 8'b1111111_1, 20);
        chk("t4_seg_err_once", 32'(se_cnt - se0), 32'd1);
        chk("t4_d3_kept", 32'(d3), 32'(6'b1_0011_0));
        chk("t4_excl", 32'(ae_cnt - ae0), 32'd1);

        // timeout on d5
        hold(8'hEF, {glyph(9), 1'b0}, STABLE + SYNC_D);
        chk("t5_capture", 32'(d5), 32'(6'b1_1001_1));
        hold(8'hFF, 8'hFF, TMO - 1);
        chk("t5_before_tmo", 32'(d5), 32'(6'b1_1001_1));
        hold(8'hFF, 8'hFF, 1);
        chk("t5_tmo", 32'(d5), 32'(6'b0_1001_1));

        // glitching cathodes never settle
        for (int i = 0; i < 12; i++)
            hold(8'hDF, {glyph((i % 2 == 0) ? 7 : 0), 1'b1}, 5);
        chk("t6_glitch_d6", 32'(d6), 32'(6'b0_0110_0));

        // reset in the middle of a stable slot
        hold(8'hBF, {glyph(3), 1'b1}, 8);
        reset = 1'b1;
        #1;
        chk("t6_rst_d5", 32'(d5), 32'h0);
        chk("t6_rst_d4", 32'(d4), 32'h0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        ft0 = ft_cnt;
        hold(8'hBF, {glyph(3), 1'b1}, STABLE - 1 + SYNC_D);
        chk("t6_post_before", 32'(d7), 32'h0);
        hold(8'hBF, {glyph(3), 1'b1}, 1);
        chk("t6_post_capture", 32'(d7), 32'(6'b1_0011_0));
        hold(8'hBF, {glyph(3), 1'b1}, 4);
        chk("t6_post_no_tick", 32'(ft_cnt - ft0), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dspl_cap_nexysa7.md
Name: dspl_cap_NexysA7

Overview:
- Receive-side counterpart of the 8-digit multiplexed 7-segment driver.
- Samples the active-low anode bus and the active-low cathode bus, and decodes each stable scan slot back into the 6-bit digit format {en, hex[3:0], dp}.
- Holds the eight reconstructed digits for loopback self-checking and board-level display monitoring.

Parameters:
- STABLE_CYCLES, 16: consecutive identical clock samples of {an, dec_cat} required before a slot is accepted.
- TIMEOUT_CYCLES, 1000000: clock cycles without a refresh of a digit before its en bit clears (10 ms at 100 MHz; one driver frame is 8 ms).

Ports:
- clock, input, 1: system clock.
- reset, input, 1: asynchronous, active-high reset.
- an, input, 8: anode bus, active low; bit k selects digit k+1.
- dec_cat, input, 8: cathodes, active low; [7:1] = segments a..g, [0] = dp.
- d1..d8, output, 6 each: captured digits; [5] = en, [4:1] = hex value, [0] = dp.
- frame_tick, output, 1: one-cycle pulse when scan wrap-around is detected.
- an_err, output, 1: one-cycle pulse on an accepted sample with more than one anode low.
- seg_err, output, 1: one-cycle pulse on an accepted single-anode sample whose segment pattern is not in the decode table.

Behaviour:
- Reset: d1..d8 = 6'd0, all pulses 0, stability counter = 0, age counters = 0, last index = 0, sample register = all ones. Reset applies immediately and may occur mid-slot; afterwards capture restarts cleanly from the next stable slot.
- Stability filter:
  - Current sample S = {an, dec_cat}, taken after the optional synchronizer.
  - If S differs from the previous sample, the counter clears to 0; otherwise it increments, saturating at STABLE_CYCLES.
  - Acceptance is one cycle, on the clock edge where the counter reaches STABLE_CYCLES-1. A held value is accepted only once.
- Accepted sample with an == 8'hFF: blank slot; nothing is captured and no pulse is raised.
- Accepted sample with exactly one low bit at index k:
  - Segment pattern in the decode table: d(k+1) <= {1, hex, ~dec_cat[0]}; age counter k clears.
  - Pattern not in the table: seg_err pulses; d(k+1) is unchanged.
- Accepted sample with two or more low bits: an_err pulses; nothing is captured.
- Decode table, dec_cat[7:1] -> hex:
  - 0000001 -> 0, 1001111 -> 1, 0010010 -> 2, 0000110 -> 3, 1001100 -> 4
  - 0100100 -> 5, 0100000 -> 6, 0001111 -> 7, 0000000 -> 8, 0000100 -> 9
  - 0111000 -> F. The driver renders all of A..F with this one glyph, so values A..F are not distinguishable and are reported as F.
- Wrap detection:
  - On each successful capture, if k <= last index, frame_tick pulses.
  - last index <= k on every successful capture.
  - The first capture after reset does not pulse frame_tick.
- Age counters:
  - Eight 32-bit counters, each incrementing every cycle and saturating.
  - When counter k reaches TIMEOUT_CYCLES, d(k+1)[5] clears; hex and dp bits are retained.
  - If a capture and the timeout occur in the same cycle, the capture wins.
- Latency: from an input change to the d update is sync depth + STABLE_CYCLES clocks. Sync depth is 2 with the optional feature, 0 without. Outputs are registered.
- an_err and seg_err are mutually exclusive. frame_tick can coincide only with a successful capture.

Optional Feature:
- Macro: DSPL_CAP_SYNC_EN.
- Defined: a 2-flop synchronizer sits on all 16 input bits, for buses arriving from pins or another clock domain; latency is STABLE_CYCLES+2.
- Undefined: inputs feed the stability filter directly, for same-clock on-chip loopback; latency is STABLE_CYCLES.

Test Plan:
- Reset held for 3 cycles, then released with an = 8'hFF: all d = 0, no pulses, for 100 cycles.
- an = 8'hFE, dec_cat = 8'b0010010_1 held for 20 cycles: d1 = 6'b1_0010_0 exactly STABLE_CYCLES (+2 if DSPL_CAP_SYNC_EN) cycles after the input change; d2..d8 remain 0.
- Scan slots 0..7 showing values 1..8 with dp on slot 3, then repeat slot 0: d4 = 6'b1_0100_1; frame_tick pulses once, on the second slot-0 capture.
- an = 8'hFC held stable: an_err pulses once and no d changes. an = 8'hFB with dec_cat[7:1] = 7'b1111111: seg_err pulses once and d3 is unchanged.
- Capture d5, then hold an = 8'hFF for TIMEOUT_CYCLES (use TIMEOUT_CYCLES = 200 in the bench): d5[5] falls at cycle 200 and d5[4:0] is retained.
- Glitch, then reset mid-slot:
  - Toggle dec_cat every 5 cycles (less than STABLE_CYCLES): no capture occurs.
  - Assert reset during a stable slot: outputs clear immediately, and the next stable slot is captured normally.
